// File: rtl/fp16_adder_if.sv
// rtl/fp16_adder_if.sv - operand/result bundle for the binary16 adder
interface fp16_adder_if;
  logic [15:0] opA_i;
  logic [15:0] opB_i;
  logic [15:0] ADD_o;

  modport master (output opA_i, output opB_i, input ADD_o);
  modport slave  (input opA_i, input opB_i, output ADD_o);
endinterface

// File: rtl/fp16_adder.sv
// rtl/fp16_adder.sv - registered IEEE 754 binary16 adder, round-to-nearest-even
module fp16_adder (
  input  logic         clk_i,
  input  logic         rst_i,
  fp16_adder_if.slave  bus
);

  function automatic logic [4:0] lzc14(input logic [13:0] v);
    lzc14 = 5'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) lzc14 = 5'(13 - i);
    end
  endfunction

  logic        sa, sb;
  logic [4:0]  xa, xb;
  logic [9:0]  fa, fb;
  logic        nan_a, nan_b, inf_a, inf_b;

  assign {sa, xa, fa} = bus.opA_i;
  assign {sb, xb, fb} = bus.opB_i;
  assign nan_a = (xa == 5'd31) && (fa != 10'd0);
  assign nan_b = (xb == 5'd31) && (fb != 10'd0);
  assign inf_a = (xa == 5'd31) && (fa == 10'd0);
  assign inf_b = (xb == 5'd31) && (fb == 10'd0);

  // Raw exp:frac bits order by magnitude; ties keep A, harmless since equal magnitudes
  logic        a_big;
  logic        sl;
  logic [4:0]  xl, xs, el, es, d;
  logic [9:0]  fl, fs;
  logic [10:0] ml, ms;

  assign a_big = bus.opA_i[14:0] >= bus.opB_i[14:0];
  assign sl    = a_big ? sa : sb;
  assign xl    = a_big ? xa : xb;
  assign fl    = a_big ? fa : fb;
  assign xs    = a_big ? xb : xa;
  assign fs    = a_big ? fb : fa;
  assign el    = (xl == 5'd0) ? 5'd1 : xl;
  assign es    = (xs == 5'd0) ? 5'd1 : xs;
  assign ml    = {xl != 5'd0, fl};
  assign ms    = {xs != 5'd0, fs};
  assign d     = el - es;

  // Significands carry three extra bits below the LSB: guard, round, sticky
  logic [27:0] ext;
  logic [13:0] ml_x, as_x, diff;
  logic [14:0] sum;
  logic        eff_sub;

  assign ext     = {ms, 17'd0} >> d;
  assign as_x    = (d >= 5'd14) ? {13'd0, |ms} : {ext[27:15], ext[14] | (|ext[13:0])};
  assign ml_x    = {ml, 3'b000};
  assign eff_sub = sa ^ sb;
  assign sum     = {1'b0, ml_x} + {1'b0, as_x};
  assign diff    = ml_x - as_x;

  // Left normalisation stops at effective exponent 1 so tiny results stay subnormal
  logic [4:0]  lz, lim, sh;
  assign lz  = lzc14(diff);
  assign lim = el - 5'd1;
  assign sh  = (lz < lim) ? lz : lim;

  logic [13:0] m_n;
  logic [5:0]  e_n, e_enc;
  logic        rnd_up;
  logic [15:0] rounded;

  always_comb begin
    m_n = 14'd0;
    e_n = 6'd0;
    if (!eff_sub) begin
      if (sum[14]) begin
        m_n = {sum[14:2], sum[1] | sum[0]};
        e_n = {1'b0, el} + 6'd1;
      end else begin
        m_n = sum[13:0];
        e_n = {1'b0, el};
      end
    end else begin
      m_n = diff << sh;
      e_n = {1'b0, el} - {1'b0, sh};
    end
  end

  // Carry out of the fraction bumps the exponent, covering subnormal-to-normal too
  assign e_enc   = m_n[13] ? e_n : 6'd0;
  assign rnd_up  = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
  assign rounded = {e_enc, m_n[12:3]} + {15'd0, rnd_up};

  logic [15:0] add_d, add_q;

  always_comb begin
    add_d = {sl, rounded[14:0]};
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      add_d = 16'h7E00;
    end else if (inf_a) begin
      add_d = bus.opA_i;
    end else if (inf_b) begin
      add_d = bus.opB_i;
    end else if (eff_sub && (diff == 14'd0)) begin
      add_d = 16'h0000;
    end else if (rounded[15:10] >= 6'd31) begin
      add_d = {sl, 5'h1F, 10'h000};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      add_q <= 16'h0000;
    end else begin
      add_q <= add_d;
    end
  end

  assign bus.ADD_o = add_q;

endmodule

// File: tb/tb_fp16_adder.sv
// tb/tb_fp16_adder.sv - directed-vector self-checking bench for fp16_adder
module tb_fp16_adder;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fp16_adder_if bus ();

  fp16_adder dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam int NV = 20;
  logic [15:0] va [NV];
  logic [15:0] vb [NV];
  logic [15:0] ve [NV];

  initial begin
    va[0]  = 16'h3E00; vb[0]  = 16'h3C00; ve[0]  = 16'h4100;
    va[1]  = 16'h4100; vb[1]  = 16'hBE00; ve[1]  = 16'h3C00;
    va[2]  = 16'h0001; vb[2]  = 16'h0001; ve[2]  = 16'h0002;
    va[3]  = 16'h0002; vb[3]  = 16'h8002; ve[3]  = 16'h0000;
    va[4]  = 16'h0400; vb[4]  = 16'h8001; ve[4]  = 16'h03FF;
    va[5]  = 16'h0001; vb[5]  = 16'h3C00; ve[5]  = 16'h3C00;
    va[6]  = 16'h3C00; vb[6]  = 16'h8001; ve[6]  = 16'h3C00;
    va[7]  = 16'h7BFF; vb[7]  = 16'h7BFF; ve[7]  = 16'h7C00;
    va[8]  = 16'h3C00; vb[8]  = 16'h1000; ve[8]  = 16'h3C00;
    va[9]  = 16'h3C01; vb[9]  = 16'h1000; ve[9]  = 16'h3C02;
    va[10] = 16'h7C00; vb[10] = 16'hFC00; ve[10] = 16'h7E00;
    va[11] = 16'h7C00; vb[11] = 16'h3C00; ve[11] = 16'h7C00;
    va[12] = 16'h7E01; vb[12] = 16'h0000; ve[12] = 16'h7E00;
    va[13] = 16'h8000; vb[13] = 16'h8000; ve[13] = 16'h8000;
    va[14] = 16'h0000; vb[14] = 16'h8000; ve[14] = 16'h0000;
    va[15] = 16'h3C00; vb[15] = 16'hBC00; ve[15] = 16'h0000;
    va[16] = 16'hFC00; vb[16] = 16'h3C00; ve[16] = 16'hFC00;
    va[17] = 16'h03FF; vb[17] = 16'h0001; ve[17] = 16'h0400;
    va[18] = 16'hFBFF; vb[18] = 16'hFBFF; ve[18] = 16'hFC00;
    va[19] = 16'h3C00; vb[19] = 16'h3C00; ve[19] = 16'h4000;
  end

  initial begin
    bus.opA_i = 16'h3C00;
    bus.opB_i = 16'h3C00;
    rst_i     = 1'b1;
    @(posedge clk_i); #1;
    check("reset_edge1", bus.ADD_o, 16'h0000);
    @(posedge clk_i); #1;
    check("reset_edge2", bus.ADD_o, 16'h0000);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("after_release", bus.ADD_o, 16'h4000);

    // Back-to-back operands: each result must land exactly one edge later
    for (int i = 0; i < NV; i++) begin
      bus.opA_i = va[i];
      bus.opB_i = vb[i];
      @(posedge clk_i); #1;
      check($sformatf("vec%0d_ab", i), bus.ADD_o, ve[i]);
    end
    for (int i = 0; i < NV; i++) begin
      bus.opA_i = vb[i];
      bus.opB_i = va[i];
      @(posedge clk_i); #1;
      check($sformatf("vec%0d_ba", i), bus.ADD_o, ve[i]);
    end

    bus.opA_i = 16'h3E00;
    bus.opB_i = 16'h3C00;
    @(posedge clk_i); #1;
    check("hold_pre", bus.ADD_o, 16'h4100);
    bus.opA_i = 16'h7BFF;
    bus.opB_i = 16'h7BFF;
    #2;
    check("hold_between_edges", bus.ADD_o, 16'h4100);

    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("midstream_reset", bus.ADD_o, 16'h0000);
    rst_i     = 1'b0;
    bus.opA_i = 16'h0001;
    bus.opB_i = 16'h0001;
    @(posedge clk_i); #1;
    check("post_reset_sum", bus.ADD_o, 16'h0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp16_adder.md
# fp16_adder

Clocked IEEE 754 binary16 (half-precision) adder producing the registered sum of two operands. It is the addition/subtraction unit of the ALU's floating-point path. Subtraction is performed by the caller flipping the sign bit of operand B. It fully supports subnormals, signed zeros, infinities and NaN, and rounds with round-to-nearest-even.

## Interface
- No parameters; format fixed at binary16: bit 15 sign, bits 14:10 exponent (bias 15), bits 9:0 fraction.
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- opA_i  input  16  operand A, binary16.
- opB_i  input  16  operand B, binary16.
- ADD_o  output  16  registered result, binary16 = round(opA_i + opB_i).

## Operation
- Unpack each operand:
  - exp 0: subnormal, significand 0.frac, effective exponent 1.
  - exp 1..30: normal, significand 1.frac.
  - exp 31: inf (frac 0) or NaN (frac ≠ 0).
- Special cases, checked first:
  - Either operand NaN → 0x7E00 (canonical quiet NaN).
  - +inf + -inf → 0x7E00.
  - inf + finite, or same-sign infs → that inf.
- Alignment:
  - Swap so the larger-magnitude operand (compare exp then frac) is first.
  - Right-shift the smaller significand by the exponent difference.
  - Keep guard, round and sticky bits. A shift ≥ 14 collapses to sticky only.
- Effective add (signs equal): add significands. On carry-out, shift right 1 and increment the exponent.
- Effective subtract: subtract smaller from larger. Normalize left by the leading-zero count, but never below effective exponent 1; the result stays subnormal at that limit.
- Sign:
  - Result sign is the sign of the larger-magnitude operand.
  - Exact-zero result from opposite signs → +0 (0x0000).
  - (-0) + (-0) → 0x8000.
  - (+0) + (-0) → 0x0000.
- Rounding:
  - Round to nearest, ties to even, using guard/round/sticky.
  - Mantissa overflow from rounding increments the exponent.
  - A subnormal rounding up to 0x0400 becomes the minimum normal.
- Overflow: exponent ≥ 31 after rounding → ±inf (0x7C00 / 0xFC00).
- Underflow: results below 2^-14 are encoded subnormal, exp field 0, frac = value·2^24, rounded. Never flush to zero.
- Datapath is combinational from opA_i/opB_i to the D-input of the output register. Width of the internal significand: 11 bits + 1 carry + 3 GRS.
- The result is commutative; swapping opA_i and opB_i yields an identical ADD_o.

## Timing
- Latency 1 cycle: operands stable before rising edge k are reflected in ADD_o after edge k.
- New operands are accepted every cycle (throughput 1/cycle).
- There is no handshake and no valid signal.
- Reset:
  - rst_i high at a rising edge → ADD_o = 0x0000; reset has priority over the computed sum.
  - The first non-reset edge after reset loads the sum of the current operands.
  - Asserting reset mid-stream discards the pending result.
- ADD_o holds its value between edges; no combinational path from inputs to output.

## Test plan
- Normal add and subtract:
  - 0x3E00 + 0x3C00 (1.5+1.0) → 0x4100 one cycle later.
  - 0x4100 + 0xBE00 (2.5−1.5) → 0x3C00.
- Subnormals:
  - 0x0001 + 0x0001 → 0x0002.
  - 0x0002 + 0x8002 → 0x0000 (+0).
  - 0x0400 + 0x8001 (min normal − min subnormal) → 0x03FF.
- Mixed magnitude, with rounding absorbing the small operand:
  - 0x0001 + 0x3C00 → 0x3C00.
  - 0x3C00 + 0x8001 → 0x3C00.
- Overflow and RNE ties:
  - 0x7BFF + 0x7BFF → 0x7C00.
  - 0x3C00 + 0x1000 (1 + 2^-11, exact tie) → 0x3C00.
  - 0x3C01 + 0x1000 → 0x3C02.
- Specials:
  - 0x7C00 + 0xFC00 → 0x7E00.
  - 0x7C00 + 0x3C00 → 0x7C00.
  - 0x7E01 + 0x0000 → 0x7E00.
  - 0x8000 + 0x8000 → 0x8000.
- Reset and pipelining:
  - Hold rst_i high for 2 edges with operands 0x3C00/0x3C00 → ADD_o = 0x0000.
  - Release → 0x4000 after the next edge.
  - Change operands every cycle → each result appears exactly one edge later.
